// File: rtl/tqvp_xoshiro_fifo_prng.sv
// tqvp_xoshiro_fifo_prng
//   TinyQV peripheral that returns xoshiro128++ words. The generator runs ahead
//   of the bus and pre-fills a DEPTH-word FIFO. A DATA read pops the FIFO head.
//   If the FIFO is empty but the generator can run, the read is stalled for one
//   cycle. If the generator cannot run (disabled or all-zero state), the read
//   returns 0 immediately and the sticky UNDERFLOW flag is set.
//
// Ports
//   clk            project clock
//   rst            synchronous active-high reset
//   ui_in[7:0]     unused
//   uo_out[7:0]    tied to 0
//   address[5:0]   byte address: 00 DATA, 04..10 SEED0..3, 14 CTRL, 18 STATUS, 1C COUNT
//   data_in[31:0]  write data
//   data_write_n   11 none, 00 byte, 01 half, 10 word
//   data_read_n    11 none, 00 byte, 01 half, 10 word
//   data_out[31:0] read data; byte/half reads are zero-extended
//   data_ready     low only while a DATA read waits for the first refill word
//   user_interrupt IRQ_EN & (FILL >= THRESH)
module tqvp_xoshiro_fifo_prng #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] SEED0 = 32'h1,
  parameter logic [31:0] SEED1 = 32'h2,
  parameter logic [31:0] SEED2 = 32'h3,
  parameter logic [31:0] SEED3 = 32'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
  localparam logic [7:0]    DEPTH_8 = 8'(DEPTH);

  localparam logic [5:0] ADDR_DATA   = 6'h00;
  localparam logic [5:0] ADDR_SEED0  = 6'h04;
  localparam logic [5:0] ADDR_SEED1  = 6'h08;
  localparam logic [5:0] ADDR_SEED2  = 6'h0C;
  localparam logic [5:0] ADDR_SEED3  = 6'h10;
  localparam logic [5:0] ADDR_CTRL   = 6'h14;
  localparam logic [5:0] ADDR_STATUS = 6'h18;
  localparam logic [5:0] ADDR_COUNT  = 6'h1C;

  logic [31:0]   s0, s1, s2, s3;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [FW-1:0] fill;
  logic [31:0]   count;
  logic          en, irq_en, underflow;
  logic [7:0]    thresh;

  logic          rd_en, wr_en, wr_word, data_rd, seed_wr;
  logic          zero_state, can_gen, fifo_empty, fifo_full;
  logic          push, pop, underflow_set;
  logic [31:0]   sum, result;
  logic [31:0]   n0, n1, n2, n3, t;
  logic [31:0]   rd_word;
  logic [7:0]    fill8;

  assign uo_out = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in};

  // Bus decode
  assign rd_en   = (data_read_n != 2'b11);
  assign wr_en   = (data_write_n != 2'b11);
  assign wr_word = (data_write_n == 2'b10);
  assign data_rd = rd_en && (address == ADDR_DATA);
  assign seed_wr = wr_word && ((address == ADDR_SEED0) || (address == ADDR_SEED1) ||
                               (address == ADDR_SEED2) || (address == ADDR_SEED3));

  assign zero_state = ~|{s0, s1, s2, s3};
  assign can_gen    = en && !zero_state;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == DEPTH_F);
  assign fill8      = 8'(fill);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop           = data_rd && !fifo_empty;
  assign underflow_set = data_rd && fifo_empty && !can_gen;
  assign push          = can_gen && !seed_wr && (!fifo_full || pop);

  // xoshiro128++ output and next state
  always_comb begin
    sum    = s0 + s3;
    result = {sum[24:0], sum[31:25]} + s0;
    t      = s1 << 9;
    n2     = s2 ^ s0;
    n3     = s3 ^ s1;
    n1     = s1 ^ n2;
    n0     = s0 ^ n3;
    n2     = n2 ^ t;
    n3     = {n3[20:0], n3[31:21]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= SEED0;
      s1 <= SEED1;
      s2 <= SEED2;
      s3 <= SEED3;
    end else if (seed_wr) begin
      case (address)
        ADDR_SEED0: s0 <= data_in;
        ADDR_SEED1: s1 <= data_in;
        ADDR_SEED2: s2 <= data_in;
        ADDR_SEED3: s3 <= data_in;
        default: ;
      endcase
    end else if (push) begin
      s0 <= n0;
      s1 <= n1;
      s2 <= n2;
      s3 <= n3;
    end
  end

  // FIFO bookkeeping; a seed write flushes and discards any push of that cycle
  always_ff @(posedge clk) begin
    if (rst || seed_wr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  // CTRL / STATUS
  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b1;
      irq_en    <= 1'b0;
      thresh    <= DEPTH_8;
      underflow <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_CTRL)) begin
        en     <= data_in[0];
        irq_en <= data_in[1];
        if (data_write_n != 2'b00) thresh <= data_in[15:8];
      end
      if (wr_en && (address == ADDR_STATUS) && (data_write_n != 2'b00) && data_in[10])
        underflow <= 1'b0;
      else if (underflow_set)
        underflow <= 1'b1;
    end
  end

  // Read path
  always_comb begin
    rd_word    = 32'h0;
    data_ready = 1'b1;
    if (rd_en) begin
      case (address)
        ADDR_DATA: begin
          if (!fifo_empty)  rd_word    = mem[rd_ptr];
          else if (can_gen) data_ready = 1'b0;
        end
        ADDR_CTRL:   rd_word = {16'h0, thresh, 6'h0, irq_en, en};
        ADDR_STATUS: rd_word = {20'h0, zero_state, underflow, fifo_empty, fifo_full, fill8};
        ADDR_COUNT:  rd_word = count;
        default:     rd_word = 32'h0;
      endcase
    end
    case (data_read_n)
      2'b00:   data_out = {24'h0, rd_word[7:0]};
      2'b01:   data_out = {16'h0, rd_word[15:0]};
      2'b10:   data_out = rd_word;
      default: data_out = 32'h0;
    endcase
  end

  assign user_interrupt = irq_en && (fill8 >= thresh);

endmodule

// File: tb/tb_tqvp_xoshiro_fifo_prng.sv
module tb_tqvp_xoshiro_fifo_prng;

  localparam int DEPTH = 4;
  localparam logic [5:0] A_DATA = 6'h00, A_SEED0 = 6'h04, A_SEED1 = 6'h08,
                         A_SEED2 = 6'h0C, A_SEED3 = 6'h10, A_CTRL = 6'h14,
                         A_STATUS = 6'h18, A_COUNT = 6'h1C;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  tqvp_xoshiro_fifo_prng #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference generator: the xoshiro128++ word stream from a seed
  logic [31:0] ms [4];
  int consumed;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  task automatic model_seed(input logic [31:0] a, b, c, d);
    ms[0] = a; ms[1] = b; ms[2] = c; ms[3] = d;
    consumed = 0;
  endtask

  task automatic model_next(output logic [31:0] w);
    logic [31:0] t;
    w = rotl32(ms[0] + ms[3], 7) + ms[0];
    t = ms[1] << 9;
    ms[2] = ms[2] ^ ms[0];
    ms[3] = ms[3] ^ ms[1];
    ms[1] = ms[1] ^ ms[2];
    ms[0] = ms[0] ^ ms[3];
    ms[2] = ms[2] ^ t;
    ms[3] = rotl32(ms[3], 11);
    consumed++;
  endtask

  function automatic logic [31:0] wmask(input logic [1:0] w);
    case (w)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: every completed read handshake is checked against the scoreboard
  always @(negedge clk) begin
    if (data_read_n != 2'b11 && data_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_handshake: addr 0x%02h data 0x%08h, no read pending", address, data_out);
      end else begin
        check($sformatf("read_0x%02h_w%0d", address, data_read_n), data_out, exp_q.pop_front());
      end
    end
  end

  task automatic bus_write(input logic [5:0] a, input logic [1:0] w, input logic [31:0] d);
    address = a; data_in = d; data_write_n = w;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [1:0] w, input logic [31:0] exp,
                          output int waits);
    exp_q.push_back(exp);
    address = a; data_read_n = w;
    waits = 0;
    forever begin
      @(negedge clk);
      if (data_ready) break;
      waits++;
      if (waits > 16) begin
        n_checks++;
        n_fail++;
        $display("FAIL read_timeout: addr 0x%02h data_ready low for %0d cycles, required <= 1", a, waits);
        void'(exp_q.pop_back());
        break;
      end
    end
    @(posedge clk); #1;
    data_read_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp);
    int w;
    bus_read(a, 2'b10, exp, w);
  endtask

  task automatic rd_data(input logic [1:0] w);
    logic [31:0] x;
    int waits;
    model_next(x);
    bus_read(A_DATA, w, x & wmask(w), waits);
  endtask

  task automatic read_burst(input int n, output int stalls);
    logic [31:0] x;
    int got;
    got = 0;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      model_next(x);
      exp_q.push_back(x);
    end
    address = A_DATA; data_read_n = 2'b10;
    while (got < n && stalls < 50) begin
      @(negedge clk);
      if (data_ready) got++;
      else stalls++;
    end
    @(posedge clk); #1;
    data_read_n = 2'b11;
    if (got < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL burst_timeout: %0d of %0d words delivered", got, n);
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_seeds(input logic [31:0] a, b, c, d);
    bus_write(A_SEED0, 2'b10, a);
    bus_write(A_SEED1, 2'b10, b);
    bus_write(A_SEED2, 2'b10, c);
    bus_write(A_SEED3, 2'b10, d);
    model_seed(a, b, c, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits, stalls, op;
    logic [1:0] w;
    logic [31:0] cnt, r0, r1, r2, r3;

    rst = 1'b1; ui_in = 8'h00; address = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    model_seed(32'h1, 32'h2, 32'h3, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_data_ready", 32'(data_ready), 32'd1);
    check("reset_data_out", data_out, 32'h0);
    check("reset_irq", 32'(user_interrupt), 32'd0);
    check("reset_uo_out", 32'(uo_out), 32'd0);
    @(posedge clk); #1;
    rd(A_CTRL, 32'h0000_0401);
    rd(A_STATUS, 32'h0000_0200);
    rd(A_COUNT, 32'h0);
    rst = 1'b0;

    // Pre-fill with no reads, then the first words of the default seed
    idle(DEPTH + 2);
    rd(A_STATUS, 32'h0000_0104);
    rd(A_COUNT, 32'd4);
    rd_data(2'b10);
    rd_data(2'b10);

    // Back-to-back reads from a full FIFO never stall
    read_burst(20, stalls);
    check("burst_full_stalls", 32'(stalls), 32'd0);

    // Unmapped addresses
    rd(6'h20, 32'h0);
    rd(6'h3C, 32'h0);
    bus_write(6'h20, 2'b10, 32'hFFFF_FFFF);
    rd(A_CTRL, 32'h0000_0401);

    // Random seed, burst from empty stalls exactly once
    r0 = $urandom | 32'h1; r1 = $urandom; r2 = $urandom; r3 = $urandom;
    write_seeds(r0, r1, r2, r3);
    read_burst(8, stalls);
    check("burst_empty_stalls", 32'(stalls), 32'd1);

    // Random mix of read widths and gaps
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 5);
      if (op <= 3) begin
        w = 2'($urandom_range(0, 2));
        rd_data(w);
      end else if (op == 4) begin
        rd(A_CTRL, 32'h0000_0401);
      end else begin
        idle($urandom_range(1, 3));
      end
    end
    idle(DEPTH + 2);
    rd(A_COUNT, 32'(consumed + DEPTH));
    rd(A_STATUS, 32'h0000_0104);

    // Narrow seed writes are ignored
    bus_write(A_SEED0, 2'b00, 32'h0);
    bus_write(A_SEED1, 2'b01, 32'h0);
    rd(A_COUNT, 32'(consumed + DEPTH));
    rd_data(2'b10);

    // Zero state and underflow
    write_seeds(32'h0, 32'h0, 32'h0, 32'h0);
    rd(A_STATUS, 32'h0000_0A00);
    rd(A_COUNT, 32'h0);
    bus_read(A_DATA, 2'b10, 32'h0, waits);
    check("zero_state_read_waits", 32'(waits), 32'd0);
    rd(A_STATUS, 32'h0000_0E00);
    bus_write(A_STATUS, 2'b10, 32'h0000_0400);
    rd(A_STATUS, 32'h0000_0A00);
    write_seeds(32'h1, 32'h2, 32'h3, 32'h4);
    rd_data(2'b10);

    // Disable with a full FIFO: drain, underflow, COUNT frozen, resume
    idle(DEPTH + 2);
    cnt = 32'(consumed + DEPTH);
    rd(A_COUNT, cnt);
    bus_write(A_CTRL, 2'b10, 32'h0000_0400);
    for (int i = 0; i < DEPTH; i++) rd_data(2'b10);
    bus_read(A_DATA, 2'b10, 32'h0, waits);
    check("disabled_underflow_waits", 32'(waits), 32'd0);
    rd(A_STATUS, 32'h0000_0600);
    rd(A_COUNT, cnt);
    bus_write(A_STATUS, 2'b10, 32'h0000_0400);
    bus_write(A_CTRL, 2'b10, 32'h0000_0401);
    rd_data(2'b10);
    rd_data(2'b01);
    rd_data(2'b10);

    // Interrupt: THRESH=2, drain with EN=0, then refill
    idle(DEPTH + 2);
    bus_write(A_CTRL, 2'b10, 32'h0000_0202);
    @(negedge clk);
    check("irq_full", 32'(user_interrupt), 32'd1);
    @(posedge clk); #1;
    rd(A_CTRL, 32'h0000_0202);
    for (int i = 0; i < DEPTH; i++) begin
      rd_data(2'b10);
      @(negedge clk);
      check($sformatf("irq_drain_fill%0d", DEPTH - 1 - i), 32'(user_interrupt),
            ((DEPTH - 1 - i) >= 2) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    bus_write(A_CTRL, 2'b10, 32'h0000_0203);
    @(negedge clk);
    check("irq_refill_fill0", 32'(user_interrupt), 32'd0);
    @(negedge clk);
    check("irq_refill_fill1", 32'(user_interrupt), 32'd0);
    @(negedge clk);
    check("irq_refill_fill2", 32'(user_interrupt), 32'd1);
    @(posedge clk); #1;
    rd_data(2'b10);

    // THRESH=0 asserts even with an empty FIFO
    bus_write(A_CTRL, 2'b10, 32'h0000_0002);
    write_seeds($urandom | 32'h1, $urandom, $urandom, $urandom);
    @(negedge clk);
    check("irq_thresh0_empty", 32'(user_interrupt), 32'd1);
    @(posedge clk); #1;
    rd(A_STATUS, 32'h0000_0200);

    // Reset during a stalled DATA read
    bus_write(A_CTRL, 2'b10, 32'h0000_0303);
    write_seeds($urandom | 32'h1, $urandom, $urandom, $urandom);
    address = A_DATA; data_read_n = 2'b10;
    @(negedge clk);
    check("stall_before_reset", 32'(data_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; data_read_n = 2'b11;
    @(negedge clk);
    check("post_reset_data_ready", 32'(data_ready), 32'd1);
    check("post_reset_data_out", data_out, 32'h0);
    check("post_reset_irq", 32'(user_interrupt), 32'd0);
    @(posedge clk); #1;
    model_seed(32'h1, 32'h2, 32'h3, 32'h4);
    rd(A_CTRL, 32'h0000_0401);
    idle(DEPTH + 2);
    rd(A_STATUS, 32'h0000_0104);
    rd(A_COUNT, 32'd4);
    rd_data(2'b10);
    rd_data(2'b00);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tqvp_xoshiro_fifo_prng.md
# tqvp_xoshiro_fifo_prng

TinyQV peripheral-bus PRNG, successor to the single-register xoshiro128++ peripheral. An internal xoshiro128++ generator pre-fills a parametrised output FIFO. Reads from the FIFO stall the bus handshake while the FIFO is refilling. The block adds a control/status register pair, a generated-word counter, a fill-threshold interrupt and zero-state protection.

## Interface
- DEPTH, 4: FIFO depth in 32-bit words; power of 2, range 2..128.
- SEED0 / SEED1 / SEED2 / SEED3, 32'h1 / 32'h2 / 32'h3 / 32'h4: generator state s0..s3 loaded at reset.
- clk  in  1  clock, TinyQV project clock.
- rst  in  1  synchronous, active-high reset; sampled on rising clk.
- ui_in  in  8  unused.
- uo_out  out  8  driven 0.
- address  in  6  byte address within peripheral.
- data_in  in  32  write data.
- data_write_n  in  2  11 none, 00 byte, 01 half, 10 word.
- data_read_n  in  2  11 none, 00 byte, 01 half, 10 word.
- data_out  out  32  read data.
- data_ready  out  1  read/handshake complete.
- user_interrupt  out  1  level interrupt.

## Operation
- Register map. Any unlisted address reads 0 and ignores writes.
  - 0x00 DATA (R): FIFO head.
  - 0x04/0x08/0x0C/0x10 SEED0..3 (W).
  - 0x14 CTRL (RW).
  - 0x18 STATUS (R, W1C).
  - 0x1C COUNT (R).
- CTRL fields: bit0 EN (reset 1); bit1 IRQ_EN (reset 0); bits[15:8] THRESH (reset DEPTH). Other bits read 0.
- STATUS fields: bits[7:0] FILL (0..DEPTH); bit8 FULL; bit9 EMPTY; bit10 UNDERFLOW (sticky); bit11 ZERO_STATE. Writing 1 to bit10 clears UNDERFLOW.
- Generator output, combinational: result = rotl(s0+s3,7)+s0, mod 2^32.
- Generator step:
  - t = s1<<9; s2^=s0; s3^=s1; s1^=s2; s0^=s3; s2^=t; s3 = rotl(s3,11).
  - Occurs together with a push of result.
- Push condition: EN=1, ZERO_STATE=0, no seed write this cycle, and (FILL<DEPTH or pop this cycle). On a push, COUNT increments; it wraps at 2^32.
- Pop condition: read of DATA (any width) with data_ready=1 in the same cycle.
  - Byte/half reads return the low 8/16 bits, upper bits 0.
  - A byte/half read still consumes the whole word.
- DATA read, FIFO non-empty: data_out = head, data_ready=1, pop.
- DATA read, FIFO empty, generator able to push: data_ready=0 until FILL>0. There is no pop during the stall.
- DATA read, FIFO empty, generator unable to push (EN=0 or ZERO_STATE): data_out=0, data_ready=1, UNDERFLOW set. There is no pop.
- Seed write: 32-bit writes only; byte/half writes to SEEDn are ignored.
  - Replaces s[n] at the clock edge.
  - Flushes the FIFO (FILL=0) and clears COUNT.
  - Pending pushes in that cycle are discarded.
- ZERO_STATE = (s0|s1|s2|s3)==0. While it is set, no push occurs and COUNT holds.
- CTRL.EN=0 freezes state and COUNT. FIFO contents are retained and remain readable.
- user_interrupt = IRQ_EN & (FILL >= THRESH). THRESH=0 with IRQ_EN=1 asserts continuously.
- Simultaneous push and pop: FILL unchanged; read pointer and write pointer both advance. Pointers wrap mod DEPTH.
- Non-DATA reads: data_ready=1, no side effects.

## Timing
- Reset values:
  - data_out=0, data_ready=1, user_interrupt=0, uo_out=0.
  - FIFO empty, COUNT=0, state = SEED0..3.
  - CTRL = EN=1, IRQ_EN=0, THRESH=DEPTH.
  - STATUS = EMPTY=1, other flags 0.
- Reset mid-stall: data_ready=1 on the first cycle with rst low. FIFO contents are lost.
- Pushes:
  - First push at the first rising edge with rst=0; FILL=1 on the following cycle.
  - FIFO full DEPTH cycles after reset deassertion, with no reads.
  - Throughput: one push per cycle.
- Stall length from empty with EN=1: data_ready low for at most 1 cycle.
- data_out and data_ready are combinational from address, data_read_n and registered state.
- Register writes take effect at the edge. Readback is valid the next cycle.
- The interrupt is registered-state derived. It reflects the new FILL one cycle after a push or pop.

## Test plan
- Defaults, reset, no reads for DEPTH+2 cycles, then 32-bit reads of DATA -> 0x00000281, 0x00180387. STATUS reads FULL=1, FILL=4 before the first read. COUNT=4 before the reads.
- Back-to-back DATA reads every cycle at DEPTH=4 -> every read returns the next xoshiro128++ word in sequence, with no data_ready stalls after the first fill and no duplicated or skipped words.
- Write SEED0..3 = 0 -> ZERO_STATE=1, FILL=0, COUNT=0. A DATA read then returns 0 with data_ready=1 and sets UNDERFLOW. Writing 1 to STATUS bit10 clears UNDERFLOW. Rewriting SEED0..3 = 1,2,3,4 gives a first word of 0x00000281.
- Disable generation:
  - Write CTRL.EN=0 with FILL=4, read DATA 5 times -> 4 valid words, then 0 with UNDERFLOW=1. COUNT is unchanged throughout.
  - Re-enabling EN resumes the sequence without a gap.
- CTRL IRQ_EN=1, THRESH=2, drain the FIFO while EN=0 -> user_interrupt falls one cycle after FILL drops to 1, and rises again after EN=1 refills FIFO to 2.
- Assert rst during a stalled DATA read -> data_ready=1 immediately after reset. All registers are at their reset values, and the first post-reset word is 0x00000281.
